// File: rtl/rtc_bus_pkg.sv
// rtl/rtc_bus_pkg.sv - state encoding, default timing and phase-length helper for the RTC bus sequencer
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    A_SETUP  = 3'd1,
    A_STROBE = 3'd2,
    A_HOLD   = 3'd3,
    D_SETUP  = 3'd4,
    D_STROBE = 3'd5,
    D_HOLD   = 3'd6,
    DONE     = 3'd7
  } state_e;

  localparam int T_SETUP_DEF = 4;
  localparam int T_PULSE_DEF = 10;
  localparam int T_HOLD_DEF  = 4;

  // Counter preload on entry to a state: the state lasts (value + 1) cycles.
  function automatic logic [7:0] phase_load(state_e s, logic [7:0] ts, logic [7:0] tp,
                                            logic [7:0] th);
    case (s)
      A_SETUP, D_SETUP:   return ts - 8'd1;
      A_STROBE, D_STROBE: return tp - 8'd1;
      A_HOLD, D_HOLD:     return th - 8'd1;
      default:            return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/rtc_bus_sequencer_bus_phase_timer.sv
// rtl/rtc_bus_sequencer_bus_phase_timer.sv - loadable 8-bit down-counter with zero flag
module bus_phase_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       cero
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != 8'd0) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  assign cero = (cnt_q == 8'd0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// rtl/rtc_bus_sequencer.sv - one multiplexed address/data RTC bus cycle per start request
// Optional read cycles and read-back data are enabled by defining RTC_READBACK_EN.
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int T_SETUP = T_SETUP_DEF,
  parameter int T_PULSE = T_PULSE_DEF,
  parameter int T_HOLD  = T_HOLD_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arranque,
  input  logic       op_leer,
  input  logic [7:0] direccion,
  input  logic [7:0] dato,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       cs_n,
  output logic       ad_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic [7:0] dato_leido,
  output logic       ocupado,
  output logic       listo
);

  state_e     state_q, state_d;
  logic [7:0] addr_q, data_q, addr_cur;
  logic       op_q, op_eff, cero, load;
  logic [7:0] bus_out_q;
  logic       bus_oe_q, cs_n_q, ad_n_q, wr_n_q, ocupado_q, listo_q;

`ifdef RTC_READBACK_EN
  logic       rd_n_q;
  logic [7:0] dato_leido_q;
  assign op_eff     = op_leer;
  assign rd_n       = rd_n_q;
  assign dato_leido = dato_leido_q;
`else
  logic unused_readback;
  assign unused_readback = ^{bus_in, op_leer};
  assign op_eff     = 1'b0;
  assign rd_n       = 1'b1;
  assign dato_leido = 8'h00;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (arranque) state_d = A_SETUP;
      A_SETUP:  if (cero) state_d = A_STROBE;
      A_STROBE: if (cero) state_d = A_HOLD;
      A_HOLD:   if (cero) state_d = D_SETUP;
      D_SETUP:  if (cero) state_d = D_STROBE;
      D_STROBE: if (cero) state_d = D_HOLD;
      D_HOLD:   if (cero) state_d = DONE;
      default:  state_d = IDLE;
    endcase
  end

  assign load = (state_d != state_q);

  bus_phase_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (phase_load(state_d, 8'(T_SETUP), 8'(T_PULSE), 8'(T_HOLD))),
    .cero     (cero)
  );

  // The address is latched on the same edge that enters A_SETUP, so bypass the latch there.
  assign addr_cur = (state_q == IDLE) ? direccion : addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      op_q      <= 1'b0;
      bus_out_q <= 8'h00;
      bus_oe_q  <= 1'b0;
      cs_n_q    <= 1'b1;
      ad_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      ocupado_q <= 1'b0;
      listo_q   <= 1'b0;
`ifdef RTC_READBACK_EN
      rd_n_q       <= 1'b1;
      dato_leido_q <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && arranque) begin
        addr_q <= direccion;
        data_q <= dato;
        op_q   <= op_eff;
      end
      bus_out_q <= 8'h00;
      bus_oe_q  <= 1'b0;
      cs_n_q    <= 1'b1;
      ad_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      listo_q   <= (state_d == DONE);
      ocupado_q <= (state_d != IDLE);
      case (state_d)
        A_SETUP, A_STROBE, A_HOLD: begin
          cs_n_q    <= 1'b0;
          ad_n_q    <= 1'b0;
          bus_oe_q  <= 1'b1;
          bus_out_q <= addr_cur;
          wr_n_q    <= (state_d != A_STROBE);
        end
        D_SETUP, D_STROBE, D_HOLD: begin
          cs_n_q    <= 1'b0;
          bus_oe_q  <= !op_q;
          bus_out_q <= op_q ? 8'h00 : data_q;
          wr_n_q    <= !(state_d == D_STROBE && !op_q);
        end
        default: ;
      endcase
`ifdef RTC_READBACK_EN
      rd_n_q <= !(state_d == D_STROBE && op_q);
      if (state_q == D_STROBE && cero && op_q) dato_leido_q <= bus_in;
`endif
    end
  end

  assign bus_out = bus_out_q;
  assign bus_oe  = bus_oe_q;
  assign cs_n    = cs_n_q;
  assign ad_n    = ad_n_q;
  assign wr_n    = wr_n_q;
  assign ocupado = ocupado_q;
  assign listo   = listo_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb/tb_rtc_bus_sequencer.sv - self-checking bench for rtc_bus_sequencer (honours RTC_READBACK_EN)
module tb_rtc_bus_sequencer;

  localparam int S = 4, P = 10, H = 4;
  localparam int L = S + P + H;
  localparam int NCYC = 2 * L + 1;

  logic       clk = 1'b0;
  logic       rst, arranque, op_leer;
  logic [7:0] direccion, dato, bus_in;
  logic [7:0] bus_out, dato_leido;
  logic       bus_oe, cs_n, ad_n, wr_n, rd_n, ocupado, listo;

  int         vectors = 0;
  int         miscompares = 0;
  int         listo_count = 0;
  logic       listo_prev;
  logic [7:0] exp_rd = 8'h00;

  always #5 clk = ~clk;

  rtc_bus_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .arranque   (arranque),
    .op_leer    (op_leer),
    .direccion  (direccion),
    .dato       (dato),
    .bus_in     (bus_in),
    .bus_out    (bus_out),
    .bus_oe     (bus_oe),
    .cs_n       (cs_n),
    .ad_n       (ad_n),
    .wr_n       (wr_n),
    .rd_n       (rd_n),
    .dato_leido (dato_leido),
    .ocupado    (ocupado),
    .listo      (listo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; the start register is cleared by the edge that sees listo high.
  task automatic step();
    listo_prev = listo;
    @(posedge clk);
    #1;
    if (listo_prev) arranque = 1'b0;
    if (listo) listo_count++;
  endtask

  function automatic logic [6:0] ctrl_vec();
    return {cs_n, ad_n, wr_n, rd_n, bus_oe, listo, ocupado};
  endfunction

  task automatic run_txn(input logic [7:0] a, input logic [7:0] d, input logic op,
                         input logic [7:0] bi, input bit chg);
    logic       rd_eff, strb;
    logic [6:0] exp_ctrl;
    logic [7:0] exp_dl;
    int         ph, j;
`ifdef RTC_READBACK_EN
    rd_eff = op;
`else
    rd_eff = 1'b0;
`endif
    direccion = a; dato = d; op_leer = op; bus_in = bi; arranque = 1'b1;
    listo_count = 0;
    step();
    for (int k = 1; k <= NCYC; k++) begin
      ph   = (k - 1) / L;
      j    = (k - 1) % L;
      strb = (j >= S) && (j < S + P);
      if (ph == 0)
        exp_ctrl = {1'b0, 1'b0, !strb, 1'b1, 1'b1, 1'b0, 1'b1};
      else if (ph == 1 && !rd_eff)
        exp_ctrl = {1'b0, 1'b1, !strb, 1'b1, 1'b1, 1'b0, 1'b1};
      else if (ph == 1)
        exp_ctrl = {1'b0, 1'b1, 1'b1, !strb, 1'b0, 1'b0, 1'b1};
      else
        exp_ctrl = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      check($sformatf("ctrl k=%0d", k), 32'(ctrl_vec()), 32'(exp_ctrl));
      if (exp_ctrl[2]) check($sformatf("bus_out k=%0d", k), 32'(bus_out), 32'(ph == 0 ? a : d));
      exp_dl = (rd_eff && k > L + S + P) ? bi : exp_rd;
      check($sformatf("dato_leido k=%0d", k), 32'(dato_leido), 32'(exp_dl));
      if (chg && k == 5) begin
        direccion = ~a; dato = ~d; op_leer = ~op;
      end
      step();
    end
    if (rd_eff) exp_rd = bi;
    repeat (3) begin
      check("idle after txn", 32'(ctrl_vec()), 32'(7'b1111000));
      step();
    end
    check("listo pulses per start", 32'(listo_count), 32'd1);
  endtask

  initial begin
    rst = 1'b1; arranque = 1'b0; op_leer = 1'b0;
    direccion = 8'h00; dato = 8'h00; bus_in = 8'h00;
    step(); step();
    check("reset ctrl", 32'(ctrl_vec()), 32'(7'b1111000));
    check("reset bus_out", 32'(bus_out), 32'h0);
    check("reset dato_leido", 32'(dato_leido), 32'h0);
    rst = 1'b0;
    step();

    run_txn(8'h21, 8'h45, 1'b0, 8'h00, 1'b0);
    run_txn(8'h21, 8'h45, 1'b0, 8'h00, 1'b1);
    run_txn(8'h22, 8'h5A, 1'b1, 8'hA5, 1'b0);
`ifdef RTC_READBACK_EN
    check("read capture", 32'(dato_leido), 32'hA5);
`else
    check("readback disabled", 32'({rd_n, dato_leido}), 32'h100);
`endif

    direccion = 8'h33; dato = 8'h66; op_leer = 1'b0; arranque = 1'b1;
    step();
    for (int k = 1; k < 15; k++) step();
    check("pre-reset busy", 32'(ocupado), 32'd1);
    rst = 1'b1; arranque = 1'b0;
    step();
    check("mid reset ctrl", 32'(ctrl_vec()), 32'(7'b1111000));
    check("mid reset bus_out", 32'(bus_out), 32'h0);
    check("mid reset dato_leido", 32'(dato_leido), 32'h0);
    exp_rd = 8'h00;
    rst = 1'b0;
    listo_count = 0;
    repeat (40) step();
    check("no listo after abort", 32'(listo_count), 32'd0);
    check("idle after abort", 32'(ctrl_vec()), 32'(7'b1111000));

    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 3)) step();
      run_txn(8'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
